// File: rtl/mult_pipe.sv
// mult_pipe: pipelined signed/unsigned multiplier with optional accumulate and valid/ready handshakes
module mult_pipe #(
  parameter int A_WIDTH = 8,
  parameter int B_WIDTH = 8,
  parameter int PIPE_STAGES = 3,
  parameter int ACC_GUARD = 4,
  localparam int RES_WIDTH = A_WIDTH + B_WIDTH + ACC_GUARD
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [A_WIDTH-1:0]   i_a,
  input  logic [B_WIDTH-1:0]   i_b,
  input  logic                 i_signed,
  input  logic                 i_acc,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [RES_WIDTH-1:0] o_result
);
  logic                 adv;
  logic                 fin_v, fin_acc;
  logic [RES_WIDTH-1:0] fin_p;
  logic                 o_valid_q, o_valid_d;
  logic [RES_WIDTH-1:0] res_q, res_d;

  // One extra operand bit carries the sign (or a zero), so both modes share one signed multiplier
  function automatic logic [RES_WIDTH-1:0] ext_mul(input logic [A_WIDTH-1:0] a,
                                                   input logic [B_WIDTH-1:0] b,
                                                   input logic s);
    logic signed [A_WIDTH:0] sa;
    logic signed [B_WIDTH:0] sb;
    sa = {s & a[A_WIDTH-1], a};
    sb = {s & b[B_WIDTH-1], b};
    return RES_WIDTH'(sa) * RES_WIDTH'(sb);
  endfunction

  assign adv      = !o_valid_q || i_ready;
  assign o_ready  = adv;
  assign o_valid  = o_valid_q;
  assign o_result = res_q;

  if (PIPE_STAGES == 1) begin : g_direct
    assign fin_v   = i_valid;
    assign fin_acc = i_acc;
    assign fin_p   = ext_mul(i_a, i_b, i_signed);
  end else begin : g_pipe
    logic                 s1_v_q, s1_v_d, s1_acc_q, s1_acc_d, s1_s_q, s1_s_d;
    logic [A_WIDTH-1:0]   s1_a_q, s1_a_d;
    logic [B_WIDTH-1:0]   s1_b_q, s1_b_d;
    logic [RES_WIDTH-1:0] s1_p;
    always_comb begin
      s1_v_d   = adv ? i_valid  : s1_v_q;
      s1_acc_d = adv ? i_acc    : s1_acc_q;
      s1_s_d   = adv ? i_signed : s1_s_q;
      s1_a_d   = adv ? i_a      : s1_a_q;
      s1_b_d   = adv ? i_b      : s1_b_q;
    end
    always_ff @(posedge clk) begin
      if (rst) s1_v_q <= 1'b0;
      else s1_v_q <= s1_v_d;
    end
    always_ff @(posedge clk) begin
      s1_acc_q <= s1_acc_d;
      s1_s_q   <= s1_s_d;
      s1_a_q   <= s1_a_d;
      s1_b_q   <= s1_b_d;
    end
    assign s1_p = ext_mul(s1_a_q, s1_b_q, s1_s_q);
    if (PIPE_STAGES == 2) begin : g_short
      assign fin_v   = s1_v_q;
      assign fin_acc = s1_acc_q;
      assign fin_p   = s1_p;
    end else begin : g_mid
      localparam int N = PIPE_STAGES - 2;
      logic [N-1:0]         mv_q, mv_d, ma_q, ma_d;
      logic [RES_WIDTH-1:0] mp_q [N];
      logic [RES_WIDTH-1:0] mp_d [N];
      always_comb begin
        mv_d    = adv ? N'({mv_q, s1_v_q})   : mv_q;
        ma_d    = adv ? N'({ma_q, s1_acc_q}) : ma_q;
        mp_d[0] = adv ? s1_p : mp_q[0];
        for (int i = 1; i < N; i++) mp_d[i] = adv ? mp_q[i-1] : mp_q[i];
      end
      always_ff @(posedge clk) begin
        if (rst) mv_q <= '0;
        else mv_q <= mv_d;
      end
      always_ff @(posedge clk) begin
        ma_q <= ma_d;
        mp_q <= mp_d;
      end
      assign fin_v   = mv_q[N-1];
      assign fin_acc = ma_q[N-1];
      assign fin_p   = mp_q[N-1];
    end
  end

  // Bubbles leave res_q untouched so a sum survives gaps in the stream
  always_comb begin
    o_valid_d = adv ? fin_v : o_valid_q;
    res_d     = (adv && fin_v) ? (fin_acc ? res_q + fin_p : fin_p) : res_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid_q <= 1'b0;
      res_q     <= '0;
    end else begin
      o_valid_q <= o_valid_d;
      res_q     <= res_d;
    end
  end
endmodule

// File: tb/tb_mult_pipe.sv
// tb_mult_pipe: directed checks of mult_pipe at 8x8, 3 stages, 4 guard bits
module tb_mult_pipe;
  localparam int RW = 20;
  logic          clk = 1'b0, rst = 1'b1, i_valid = 1'b0, i_signed = 1'b0, i_acc = 1'b0, i_ready = 1'b1;
  logic          o_ready, o_valid;
  logic [7:0]    i_a = '0, i_b = '0;
  logic [RW-1:0] o_result;
  int            n_vec = 0, n_bad = 0;
  logic [RW-1:0] got_q[$];
  logic [RW-1:0] exp_q[$];

  mult_pipe #(.A_WIDTH(8), .B_WIDTH(8), .PIPE_STAGES(3), .ACC_GUARD(4)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_a(i_a), .i_b(i_b),
    .i_signed(i_signed), .i_acc(i_acc), .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (!rst && o_valid && i_ready) got_q.push_back(o_result);

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input logic [7:0] a, input logic [7:0] b, input logic s, input logic acc,
                      input logic [RW-1:0] exp);
    logic done;
    done = 1'b0;
    i_valid = 1'b1; i_a = a; i_b = b; i_signed = s; i_acc = acc;
    for (int t = 0; t < 20 && !done; t++) begin
      @(posedge clk);
      done = o_ready;
      #1;
    end
    check("accept", done, 1);
    i_valid = 1'b0;
    exp_q.push_back(exp);
  endtask

  task automatic check_seq(input string tag);
    for (int t = 0; t < 60 && got_q.size() < exp_q.size(); t++) tick();
    check({tag, "_count"}, got_q.size(), exp_q.size());
    foreach (exp_q[i]) check(tag, i < got_q.size() ? got_q[i] : 'x, exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [RW-1:0] sum;
    i_valid = 1'b1; i_a = 8'd3; i_b = 8'd3;
    tick(); tick();
    rst = 1'b0; i_valid = 1'b0;
    check("rst_valid", o_valid, 0);
    check("rst_result", o_result, 0);
    check("rst_ready", o_ready, 1);
    repeat (5) tick();
    check("rst_no_output", got_q.size(), 0);

    i_valid = 1'b1; i_a = 8'hFF; i_b = 8'hFF; i_signed = 1'b0; i_acc = 1'b0;
    tick();
    i_valid = 1'b0;
    check("lat_edge1", o_valid, 0);
    tick();
    check("lat_edge2", o_valid, 0);
    tick();
    check("lat_edge3", o_valid, 1);
    check("umax", o_result, 20'h0FE01);
    tick();
    got_q.delete();

    xfer(8'hFF, 8'h02, 1'b1, 1'b0, 20'hFFFFE);
    xfer(8'hFF, 8'h02, 1'b0, 1'b0, 20'h001FE);
    xfer(8'h80, 8'h80, 1'b1, 1'b0, 20'h04000);
    check_seq("signed");

    fork
      for (int i = 1; i <= 5; i++) xfer(8'(i), 8'(i), 1'b0, 1'b0, RW'(i * i));
      begin
        for (int t = 0; t < 20 && !o_valid; t++) tick();
        i_ready = 1'b0;
        for (int t = 0; t < 3; t++) begin
          tick();
          check("stall_hold", o_result, 1);
          check("stall_ready", o_ready, 0);
        end
        i_ready = 1'b1;
      end
    join
    check_seq("backpressure");

    xfer(8'd3, 8'd4, 1'b0, 1'b0, 20'd12);
    xfer(8'd5, 8'd6, 1'b0, 1'b1, 20'd42);
    tick();
    xfer(8'd2, 8'd2, 1'b0, 1'b1, 20'd46);
    xfer(8'd7, 8'd1, 1'b0, 1'b0, 20'd7);
    xfer(8'hFF, 8'h01, 1'b1, 1'b0, 20'hFFFFF);
    xfer(8'h02, 8'h02, 1'b0, 1'b1, 20'd3);
    check_seq("accumulate");

    sum = '0;
    for (int k = 0; k < 17; k++) begin
      sum = (k == 0) ? 20'd65025 : sum + 20'd65025;
      xfer(8'hFF, 8'hFF, 1'b0, k != 0, sum);
    end
    check_seq("wrap");
    check("wrap_final", o_result, 20'h0DE11);

    xfer(8'd9, 8'd9, 1'b0, 1'b0, 20'd0);
    xfer(8'd10, 8'd10, 1'b0, 1'b0, 20'd0);
    exp_q.delete();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_valid", o_valid, 0);
    check("midrst_result", o_result, 0);
    repeat (6) tick();
    check("midrst_dropped", got_q.size(), 0);
    xfer(8'd6, 8'd7, 1'b0, 1'b1, 20'd42);
    check_seq("midrst_acc");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/mult_pipe.md
Name: mult_pipe

Overview:
- Parametrised, pipelined integer multiplier with an optional accumulator.
- Successor to the fixed 4x4 registered multiplier. Adds configurable operand widths and pipeline depth, per-transaction signed/unsigned mode, and multiply-accumulate.
- Adds valid/ready handshakes with backpressure on both sides.
- Single clock domain. Any operand from another domain is synchronised upstream before it reaches this block.

Parameters:
- A_WIDTH, 8, operand A width in bits (>=2)
- B_WIDTH, 8, operand B width in bits (>=2)
- PIPE_STAGES, 3, total register stages from operand capture to o_result, counting the output register (>=1)
- ACC_GUARD, 4, extra accumulator guard bits; RES_WIDTH = A_WIDTH+B_WIDTH+ACC_GUARD

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- i_valid  in  1  input transaction valid
- o_ready  out  1  block can accept; a transfer occurs when i_valid&&o_ready at a rising edge
- i_a  in  A_WIDTH  operand A
- i_b  in  B_WIDTH  operand B
- i_signed  in  1  1: two's-complement operands; 0: unsigned
- i_acc  in  1  1: add product to accumulator; 0: start a new sum with this product
- o_valid  out  1  result valid
- i_ready  in  1  downstream accepts; a result is consumed when o_valid&&i_ready at a rising edge
- o_result  out  RES_WIDTH  product or accumulated sum

Behaviour:
- Reset (rst high at an edge): all stage valid bits, o_valid and o_result clear to 0. o_ready is 1 in the cycle after reset.
- In-flight transactions are discarded on reset; the accumulator restarts from 0.
- Stall: advance = !o_valid || i_ready, and o_ready = advance.
  - When advance=0 every stage register holds, including its data, valid and flag bits. No bubble compression is required.
- Latency: a transfer accepted at edge k with no stalls gives o_valid=1 after edge k+PIPE_STAGES-1.
  - PIPE_STAGES=1: the result is visible in the cycle after acceptance.
  - Each stall cycle adds one cycle of latency.
- Throughput: one transaction per cycle while i_ready stays high.
- Ordering is preserved; no transaction is dropped or duplicated.
- Stage 1 captures i_a, i_b, i_signed and i_acc.
- Product width is A_WIDTH+B_WIDTH.
  - signed=1: operands are sign-extended and the product is sign-extended to RES_WIDTH.
  - signed=0: the product is zero-extended to RES_WIDTH.
- The product may be computed in any stage before the last; intermediate register placement is implementation choice provided the latency is exact.
- Final stage, when a valid entry loads into o_result:
  - o_result <= acc ? (o_result + product_ext) : product_ext
  - The accumulator is the current o_result register, i.e. the last value loaded, whether or not it was consumed.
- Arithmetic is modulo 2^RES_WIDTH. Wrap-around is silent; there is no saturation or overflow flag.
- Bubbles (an invalid entry reaching the final stage while advancing): o_valid <= 0 and o_result holds its value, so accumulation continues across gaps.
- o_result holds while o_valid=1 && i_ready=0.
- The signed flag applies per transaction. Mixing modes within an accumulation is legal: sign- or zero-extension is applied per product before adding.
- Simultaneous consume and load in the same cycle is legal: the new result replaces the old one at that edge.
- No combinational path from i_valid to o_ready. A combinational path from i_ready to o_ready is allowed.

Test Plan:
Test parameters: A_WIDTH=8, B_WIDTH=8, PIPE_STAGES=3, ACC_GUARD=4, RES_WIDTH=20.
- Reset: hold rst 2 cycles with i_valid=1 -> o_valid=0, o_result=0x00000, o_ready=1 after release; no result emitted.
- Unsigned max: a=0xFF, b=0xFF, signed=0, acc=0, i_ready=1 -> o_valid high 3 edges after acceptance, o_result=0x0FE01.
- Signed vs unsigned: a=0xFF, b=0x02 with signed=1 -> 0xFFFFE (-2); same operands with signed=0 -> 0x001FE. Also a=0x80, b=0x80 signed -> 0x04000.
- Backpressure: stream 5 transactions back to back (1*1 .. 5*5); drop i_ready for 3 cycles after the first result.
  - Required: outputs 1, 4, 9, 16, 25 in order.
  - Required: o_result stable and o_ready=0 while stalled; no loss.
- Accumulate: 3*4 acc=0, then 5*6 acc=1, then a bubble, then 2*2 acc=1 -> 12, 42, 46. Then 7*1 acc=0 -> 7.
  - Wrap: 17 x (0xFF*0xFF, acc=1, after an acc=0 start) -> final o_result=56849 (0x0DE11).
- Reset mid-operation: assert rst for 1 cycle with 2 transactions in flight -> o_valid=0 next cycle and neither result ever appears. A following 6*7 acc=1 yields 42.
